// File: rtl/load_store_unit_pkg.sv
// rtl/load_store_unit_pkg.sv - funct3 width codes, FSM states and size decode for the LSU
package load_store_unit_pkg;

  // RV32I load/store width codes
  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_REQUEST = 2'd1,
    ST_WAIT    = 2'd2
  } lsu_state_t;

  typedef enum logic [1:0] {
    SZ_B = 2'd0,
    SZ_H = 2'd1,
    SZ_W = 2'd2
  } access_size_t;

  // Unused codes (011, 110, 111) fall through to a full word access
  function automatic access_size_t size_of(input logic [2:0] funct3);
    case (funct3)
      F3_B, F3_BU: size_of = SZ_B;
      F3_H, F3_HU: size_of = SZ_H;
      default:     size_of = SZ_W;
    endcase
  endfunction

endpackage

// File: rtl/load_store_unit_load_aligner.sv
// rtl/load_store_unit_load_aligner.sv - shifts a read word down to its byte offset and extends it
module load_store_unit_load_aligner
  import load_store_unit_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  offset,
  input  logic [2:0]  funct3,
  output logic [31:0] data
);

  logic [31:0] shifted;

  // Right-shift by whole bytes, then sign- or zero-extend by width code
  always_comb begin
    shifted = rdata >> {offset, 3'b000};
    case (funct3)
      F3_B:    data = {{24{shifted[7]}}, shifted[7:0]};
      F3_BU:   data = {24'd0, shifted[7:0]};
      F3_H:    data = {{16{shifted[15]}}, shifted[15:0]};
      F3_HU:   data = {16'd0, shifted[15:0]};
      default: data = shifted;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// rtl/load_store_unit.sv - single-outstanding load/store unit; optional LSU_MISALIGN_TRAP_EN adds misaligned trap port
module load_store_unit
  import load_store_unit_pkg::*;
#(
  parameter int ADDRESS_WIDTH = 32,
  parameter int DATA_WIDTH    = 32
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     ex_valid,
  output logic                     ex_ready,
  input  logic                     ex_load,
  input  logic                     ex_store,
  input  logic [2:0]               ex_funct3,
  input  logic [ADDRESS_WIDTH-1:0] ex_address,
  input  logic [31:0]              ex_store_data,
  input  logic [4:0]               ex_rd,
  output logic                     mem_req,
  output logic                     mem_we,
  output logic [ADDRESS_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0]    mem_wdata,
  output logic [3:0]               mem_be,
  input  logic                     mem_gnt,
  input  logic                     mem_rvalid,
  input  logic [DATA_WIDTH-1:0]    mem_rdata,
`ifdef LSU_MISALIGN_TRAP_EN
  output logic                     misaligned,
`endif
  output logic                     wb_valid,
  output logic [4:0]               wb_rd,
  output logic [31:0]              wb_data
);

  lsu_state_t   state, next_state;
  access_size_t ex_size;
  logic [1:0]   ex_offset;
  logic         offer;
  logic         trap;
  logic         take;
  logic         store_q;
  logic [2:0]   funct3_q;
  logic [1:0]   offset_q;
  logic [4:0]   rd_q;
  logic [31:0]  aligned;

  assign ex_size = size_of(ex_funct3);
  // Low address bits that don't belong to the access width are dropped
  assign ex_offset = (ex_size == SZ_B) ? ex_address[1:0] :
                     (ex_size == SZ_H) ? {ex_address[1], 1'b0} : 2'b00;
  assign offer = (state == ST_IDLE) && ex_valid && (ex_load || ex_store);

`ifdef LSU_MISALIGN_TRAP_EN
  assign trap = ((ex_size == SZ_H) && ex_address[0]) ||
                ((ex_size == SZ_W) && (ex_address[1:0] != 2'b00));
`else
  assign trap = 1'b0;
`endif

  assign take = offer && !trap;

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= ST_IDLE;
    else       state <= next_state;
  end

  // Next-state logic
  always_comb begin
    next_state = state;
    case (state)
      ST_IDLE:    if (take) next_state = ST_REQUEST;
      ST_REQUEST: if (mem_gnt) next_state = store_q ? ST_IDLE : ST_WAIT;
      ST_WAIT:    if (mem_rvalid) next_state = ST_IDLE;
      default:    next_state = ST_IDLE;
    endcase
  end

  // FSM-decoded outputs
  always_comb begin
    ex_ready = (state == ST_IDLE);
    mem_req  = (state == ST_REQUEST);
    mem_we   = (state == ST_REQUEST) && store_q;
  end

  // Capture the accepted instruction and pre-compute the memory request fields
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      store_q   <= 1'b0;
      funct3_q  <= 3'b000;
      offset_q  <= 2'b00;
      rd_q      <= 5'd0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_be    <= 4'b0000;
    end else if (take) begin
      store_q  <= ex_store;
      funct3_q <= ex_funct3;
      offset_q <= ex_offset;
      rd_q     <= ex_rd;
      mem_addr <= {ex_address[ADDRESS_WIDTH-1:2], 2'b00};
      case (ex_size)
        SZ_B: begin
          mem_be    <= 4'b0001 << ex_offset;
          mem_wdata <= {4{ex_store_data[7:0]}};
        end
        SZ_H: begin
          mem_be    <= 4'b0011 << ex_offset;
          mem_wdata <= {2{ex_store_data[15:0]}};
        end
        default: begin
          mem_be    <= 4'b1111;
          mem_wdata <= ex_store_data;
        end
      endcase
    end
  end

`ifdef LSU_MISALIGN_TRAP_EN
  // One-cycle trap pulse after a misaligned offer is consumed
  always_ff @(posedge clk or posedge reset) begin
    if (reset) misaligned <= 1'b0;
    else       misaligned <= offer && trap;
  end
`endif

  load_store_unit_load_aligner u_load_aligner (
    .rdata  (mem_rdata[31:0]),
    .offset (offset_q),
    .funct3 (funct3_q),
    .data   (aligned)
  );

  // Register the write-back result for one cycle when read data returns
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wb_valid <= 1'b0;
      wb_rd    <= 5'd0;
      wb_data  <= 32'd0;
    end else begin
      wb_valid <= (state == ST_WAIT) && mem_rvalid;
      if ((state == ST_WAIT) && mem_rvalid) begin
        wb_rd   <= rd_q;
        wb_data <= aligned;
      end
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// tb/tb_load_store_unit.sv - directed vector bench for load_store_unit
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        ex_valid, ex_ready, ex_load, ex_store;
  logic [2:0]  ex_funct3;
  logic [31:0] ex_address, ex_store_data;
  logic [4:0]  ex_rd;
  logic        mem_req, mem_we, mem_gnt, mem_rvalid;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  mem_be;
  logic        wb_valid;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
`ifdef LSU_MISALIGN_TRAP_EN
  logic        misaligned;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  load_store_unit #(.ADDRESS_WIDTH(32), .DATA_WIDTH(32)) dut (
    .clk           (clk),
    .reset         (reset),
    .ex_valid      (ex_valid),
    .ex_ready      (ex_ready),
    .ex_load       (ex_load),
    .ex_store      (ex_store),
    .ex_funct3     (ex_funct3),
    .ex_address    (ex_address),
    .ex_store_data (ex_store_data),
    .ex_rd         (ex_rd),
    .mem_req       (mem_req),
    .mem_we        (mem_we),
    .mem_addr      (mem_addr),
    .mem_wdata     (mem_wdata),
    .mem_be        (mem_be),
    .mem_gnt       (mem_gnt),
    .mem_rvalid    (mem_rvalid),
    .mem_rdata     (mem_rdata),
`ifdef LSU_MISALIGN_TRAP_EN
    .misaligned    (misaligned),
`endif
    .wb_valid      (wb_valid),
    .wb_rd         (wb_rd),
    .wb_data       (wb_data)
  );

  typedef struct {
    logic        st;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] sdata;
    logic [31:0] rdata;
    int          gnt_dly;
    logic [31:0] e_addr;
    logic [3:0]  e_be;
    logic [31:0] e_wdata;
    logic [31:0] e_wb;
  } vec_t;

  vec_t vecs[12];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic offer(input logic st, input logic ld, input logic [2:0] f3,
                       input logic [31:0] addr, input logic [31:0] sdata, input logic [4:0] rd);
    ex_valid      = 1'b1;
    ex_store      = st;
    ex_load       = ld;
    ex_funct3     = f3;
    ex_address    = addr;
    ex_store_data = sdata;
    ex_rd         = rd;
    tick();
    ex_valid = 1'b0;
    ex_load  = 1'b0;
    ex_store = 1'b0;
  endtask

  // Full transaction: offer, request with optional grant delay, and read return for loads
  task automatic run_vec(input vec_t v, input logic [4:0] rd, input string tag);
    offer(v.st, !v.st, v.f3, v.addr, v.sdata, rd);
    check({tag, " req"}, {31'd0, mem_req}, 32'd1);
    check({tag, " ready"}, {31'd0, ex_ready}, 32'd0);
    check({tag, " we"}, {31'd0, mem_we}, {31'd0, v.st});
    check({tag, " addr"}, mem_addr, v.e_addr);
    if (v.st) begin
      check({tag, " be"}, {28'd0, mem_be}, {28'd0, v.e_be});
      check({tag, " wdata"}, mem_wdata, v.e_wdata);
    end
    for (int k = 0; k < v.gnt_dly; k++) begin
      tick();
      check({tag, " req held"}, {31'd0, mem_req}, 32'd1);
      check({tag, " addr held"}, mem_addr, v.e_addr);
      check({tag, " ready held"}, {31'd0, ex_ready}, 32'd0);
    end
    mem_gnt = 1'b1;
    tick();
    mem_gnt = 1'b0;
    check({tag, " req drop"}, {31'd0, mem_req}, 32'd0);
    if (v.st) begin
      check({tag, " idle ready"}, {31'd0, ex_ready}, 32'd1);
      tick();
      check({tag, " no wb"}, {31'd0, wb_valid}, 32'd0);
    end else begin
      check({tag, " wait ready"}, {31'd0, ex_ready}, 32'd0);
      mem_rvalid = 1'b1;
      mem_rdata  = v.rdata;
      tick();
      mem_rvalid = 1'b0;
      check({tag, " wb_valid"}, {31'd0, wb_valid}, 32'd1);
      check({tag, " wb_data"}, wb_data, v.e_wb);
      check({tag, " wb_rd"}, {27'd0, wb_rd}, {27'd0, rd});
      tick();
      check({tag, " wb pulse"}, {31'd0, wb_valid}, 32'd0);
    end
  endtask

  initial begin
    vec_t mis;
    reset = 1'b1;
    ex_valid = 0; ex_load = 0; ex_store = 0; ex_funct3 = 0;
    ex_address = 0; ex_store_data = 0; ex_rd = 0;
    mem_gnt = 0; mem_rvalid = 0; mem_rdata = 0;

    //          st  f3      addr          sdata         rdata         dly e_addr        e_be     e_wdata       e_wb
    vecs[0]  = '{0, 3'b000, 32'h0000_0103, 32'h0,        32'h80FF_1234, 0, 32'h0000_0100, 4'b0000, 32'h0,        32'hFFFF_FF80};
    vecs[1]  = '{1, 3'b001, 32'h0000_0202, 32'h0000_BEEF, 32'h0,        0, 32'h0000_0200, 4'b1100, 32'hBEEF_BEEF, 32'h0};
    vecs[2]  = '{0, 3'b010, 32'h0000_0300, 32'h0,        32'h1234_5678, 3, 32'h0000_0300, 4'b0000, 32'h0,        32'h1234_5678};
    vecs[3]  = '{0, 3'b100, 32'h0000_0101, 32'h0,        32'h1234_A5CD, 0, 32'h0000_0100, 4'b0000, 32'h0,        32'h0000_00A5};
    vecs[4]  = '{0, 3'b001, 32'h0000_0002, 32'h0,        32'h8001_7FFF, 0, 32'h0000_0000, 4'b0000, 32'h0,        32'hFFFF_8001};
    vecs[5]  = '{0, 3'b101, 32'h0000_0002, 32'h0,        32'h8001_7FFF, 1, 32'h0000_0000, 4'b0000, 32'h0,        32'h0000_8001};
    vecs[6]  = '{1, 3'b000, 32'h0000_0007, 32'h1234_56AB, 32'h0,        0, 32'h0000_0004, 4'b1000, 32'hABAB_ABAB, 32'h0};
    vecs[7]  = '{1, 3'b010, 32'h0000_0010, 32'hDEAD_BEEF, 32'h0,        2, 32'h0000_0010, 4'b1111, 32'hDEAD_BEEF, 32'h0};
    vecs[8]  = '{0, 3'b011, 32'h0000_0020, 32'h0,        32'hCAFE_F00D, 0, 32'h0000_0020, 4'b0000, 32'h0,        32'hCAFE_F00D};
    vecs[9]  = '{1, 3'b110, 32'h0000_0024, 32'h0102_0304, 32'h0,        0, 32'h0000_0024, 4'b1111, 32'h0102_0304, 32'h0};
    vecs[10] = '{1, 3'b000, 32'h0000_0001, 32'h0000_005A, 32'h0,        1, 32'h0000_0000, 4'b0010, 32'h5A5A_5A5A, 32'h0};
    vecs[11] = '{0, 3'b001, 32'h0000_0000, 32'h0,        32'h1234_F00F, 0, 32'h0000_0000, 4'b0000, 32'h0,        32'hFFFF_F00F};

    // Reset state
    #2;
    check("rst ready", {31'd0, ex_ready}, 32'd1);
    check("rst req", {31'd0, mem_req}, 32'd0);
    check("rst we", {31'd0, mem_we}, 32'd0);
    check("rst addr", mem_addr, 32'd0);
    check("rst wdata", mem_wdata, 32'd0);
    check("rst be", {28'd0, mem_be}, 32'd0);
    check("rst wb_valid", {31'd0, wb_valid}, 32'd0);
    check("rst wb_data", wb_data, 32'd0);
    check("rst wb_rd", {27'd0, wb_rd}, 32'd0);
    tick();
    reset = 1'b0;
    tick();

    for (int i = 0; i < 12; i++) begin
      run_vec(vecs[i], 5'(i + 1), $sformatf("vec%0d", i));
    end

    // Offer with neither load nor store is consumed silently
    offer(1'b0, 1'b0, 3'b010, 32'h0000_0040, 32'h0, 5'd3);
    check("nop req", {31'd0, mem_req}, 32'd0);
    check("nop ready", {31'd0, ex_ready}, 32'd1);

    // Store wins over load when both are set
    offer(1'b1, 1'b1, 3'b010, 32'h0000_0044, 32'h1111_2222, 5'd4);
    check("prio we", {31'd0, mem_we}, 32'd1);
    mem_gnt = 1'b1;
    tick();
    mem_gnt = 1'b0;
    check("prio idle", {31'd0, ex_ready}, 32'd1);

    // Misaligned word store
`ifdef LSU_MISALIGN_TRAP_EN
    offer(1'b1, 1'b0, 3'b010, 32'h0000_0001, 32'hA5A5_A5A5, 5'd0);
    check("mis pulse", {31'd0, misaligned}, 32'd1);
    check("mis no req", {31'd0, mem_req}, 32'd0);
    check("mis ready", {31'd0, ex_ready}, 32'd1);
    tick();
    check("mis one cycle", {31'd0, misaligned}, 32'd0);
    check("mis no req 2", {31'd0, mem_req}, 32'd0);
`else
    mis = '{1, 3'b010, 32'h0000_0001, 32'hA5A5_A5A5, 32'h0, 0, 32'h0, 4'b1111, 32'hA5A5_A5A5, 32'h0};
    run_vec(mis, 5'd0, "mis sw");
    mis = '{0, 3'b001, 32'h0000_0003, 32'h0, 32'h8001_7FFF, 0, 32'h0, 4'b0000, 32'h0, 32'hFFFF_8001};
    run_vec(mis, 5'd9, "mis lh");
`endif

    // Reset while a request is pending
    offer(1'b0, 1'b1, 3'b010, 32'h0000_0080, 32'h0, 5'd6);
    check("rreq req", {31'd0, mem_req}, 32'd1);
    reset = 1'b1;
    #1;
    check("rreq async req", {31'd0, mem_req}, 32'd0);
    check("rreq async addr", mem_addr, 32'd0);
    check("rreq async ready", {31'd0, ex_ready}, 32'd1);
    tick();
    reset = 1'b0;

    // Reset while waiting for read data, then a late read return
    offer(1'b0, 1'b1, 3'b010, 32'h0000_0090, 32'h0, 5'd7);
    mem_gnt = 1'b1;
    tick();
    mem_gnt = 1'b0;
    check("rwait in wait", {31'd0, ex_ready}, 32'd0);
    reset = 1'b1;
    #1;
    check("rwait req", {31'd0, mem_req}, 32'd0);
    check("rwait ready", {31'd0, ex_ready}, 32'd1);
    tick();
    reset = 1'b0;
    mem_rvalid = 1'b1;
    mem_rdata  = 32'hDEAD_DEAD;
    tick();
    mem_rvalid = 1'b0;
    check("rwait no wb", {31'd0, wb_valid}, 32'd0);
    tick();
    check("rwait no wb 2", {31'd0, wb_valid}, 32'd0);
    run_vec(vecs[0], 5'd31, "post rst");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
